// File: rtl/niosii_system_sysid_check_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the
// system ID peripheral (slave).
interface niosii_system_sysid_check_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/niosii_system_sysid_check.sv
// Reads the sysid ID and timestamp words once per start and flags whether they
// match the values this bitstream was built with; each transfer is time-bounded.
module niosii_system_sysid_check #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1487538347,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    niosii_system_sysid_check_if.master         avm,
    output logic                                busy,
    output logic                                done,
    output logic                                id_ok,
    output logic                                ts_ok,
    output logic                                timeout_err,
    output logic [31:0]                         captured_id,
    output logic [31:0]                         captured_ts
);
    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        FINISH
    } state_t;

    // Counter value seen in the last cycle a transfer is still allowed to complete.
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [15:0] count_reg;
    logic        avm_read_reg;
    logic        avm_address_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        id_ok_reg;
    logic        ts_ok_reg;
    logic        timeout_err_reg;
    logic [31:0] captured_id_reg;
    logic [31:0] captured_ts_reg;

    logic in_req;
    logic ts_phase;
    logic resp_valid;
    logic timed_out;

    assign in_req   = (state_reg == REQ_ID) || (state_reg == REQ_TS);
    assign ts_phase = (state_reg == REQ_TS) || (state_reg == WAIT_TS);
    // A response counts in REQ only together with its accept; earlier strobes are strays.
    assign resp_valid = avm.avm_readdatavalid && (!in_req || !avm.avm_waitrequest);
    assign timed_out  = (count_reg == LAST_COUNT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            avm_read_reg    <= 1'b0;
            avm_address_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            id_ok_reg       <= 1'b0;
            ts_ok_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
            captured_id_reg <= '0;
            captured_ts_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    if (start) begin
                        id_ok_reg       <= 1'b0;
                        ts_ok_reg       <= 1'b0;
                        timeout_err_reg <= 1'b0;
                        captured_id_reg <= '0;
                        captured_ts_reg <= '0;
                        avm_read_reg    <= 1'b1;
                        avm_address_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= REQ_ID;
                    end
                end
                REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
                    if (resp_valid) begin
                        if (ts_phase) begin
                            captured_ts_reg <= avm.avm_readdata;
                            ts_ok_reg       <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
                            avm_read_reg    <= 1'b0;
                            busy_reg        <= 1'b0;
                            done_reg        <= 1'b1;
                            state_reg       <= FINISH;
                        end else begin
                            captured_id_reg <= avm.avm_readdata;
                            id_ok_reg       <= (avm.avm_readdata == EXPECTED_ID);
                            avm_read_reg    <= 1'b1;
                            avm_address_reg <= 1'b1;
                            count_reg       <= '0;
                            state_reg       <= REQ_TS;
                        end
                    end else if (timed_out) begin
                        // Abandon the sequence: later reads are never issued.
                        timeout_err_reg <= 1'b1;
                        avm_read_reg    <= 1'b0;
                        busy_reg        <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= FINISH;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                        if (in_req && !avm.avm_waitrequest) begin
                            avm_read_reg <= 1'b0;
                            state_reg    <= ts_phase ? WAIT_TS : WAIT_ID;
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign avm.avm_read    = avm_read_reg;
    assign avm.avm_address = avm_address_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign id_ok           = id_ok_reg;
    assign ts_ok           = ts_ok_reg;
    assign timeout_err     = timeout_err_reg;
    assign captured_id     = captured_id_reg;
    assign captured_ts     = captured_ts_reg;
endmodule
